// File: rtl/diff_commit_packer.sv
// Difftest commit producer: packs up to COMMIT_W retiring instructions into ordered
// slots with running commit indices, and streams retired stores out one per cycle.
module diff_commit_packer #(
  parameter int unsigned COMMIT_W  = 4,
  parameter int unsigned STQ_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMIT_W-1:0]     in_valid,
  input  logic [COMMIT_W*32-1:0]  in_pc,
  input  logic [COMMIT_W*32-1:0]  in_instr,
  input  logic [COMMIT_W-1:0]     in_wen,
  input  logic [COMMIT_W*5-1:0]   in_wdest,
  input  logic [COMMIT_W*32-1:0]  in_wdata,
  input  logic [COMMIT_W-1:0]     in_st,
  input  logic [COMMIT_W*32-1:0]  in_st_paddr,
  input  logic [COMMIT_W*32-1:0]  in_st_vaddr,
  input  logic [COMMIT_W*32-1:0]  in_st_data,
  input  logic [COMMIT_W*8-1:0]   in_st_kind,
  output logic                    commit_ready,
  output logic [COMMIT_W-1:0]     out_valid,
  output logic [COMMIT_W*8-1:0]   out_index,
  output logic [COMMIT_W*64-1:0]  out_pc,
  output logic [COMMIT_W*32-1:0]  out_instr,
  output logic [COMMIT_W-1:0]     out_wen,
  output logic [COMMIT_W*8-1:0]   out_wdest,
  output logic [COMMIT_W*64-1:0]  out_wdata,
  output logic [7:0]              st_valid,
  output logic [7:0]              st_index,
  output logic [63:0]             st_paddr,
  output logic [63:0]             st_vaddr,
  output logic [63:0]             st_data,
  output logic                    st_overflow
);

  localparam int unsigned PtrW = $clog2(STQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // ---------------- commit slot compaction ----------------
  logic [7:0]             base_q, base_d;
  logic [COMMIT_W-1:0]    valid_q, valid_d;
  logic [COMMIT_W*8-1:0]  index_q, index_d;
  logic [COMMIT_W*64-1:0] pc_q, pc_d;
  logic [COMMIT_W*32-1:0] instr_q, instr_d;
  logic [COMMIT_W-1:0]    wen_q, wen_d;
  logic [COMMIT_W*8-1:0]  wdest_q, wdest_d;
  logic [COMMIT_W*64-1:0] wdata_q, wdata_d;

  // Slot j takes the j-th valid port; unused slots stay all-zero.
  always_comb begin
    int slot;
    slot    = 0;
    valid_d = '0;
    index_d = '0;
    pc_d    = '0;
    instr_d = '0;
    wen_d   = '0;
    wdest_d = '0;
    wdata_d = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (in_valid[k]) begin
        valid_d[slot]              = 1'b1;
        index_d[slot*8 +: 8]       = base_q + 8'(slot + 1);
        pc_d[slot*64 +: 64]        = {32'd0, in_pc[k*32 +: 32]};
        instr_d[slot*32 +: 32]     = in_instr[k*32 +: 32];
        wen_d[slot]                = in_wen[k];
        wdest_d[slot*8 +: 8]       = {3'd0, in_wdest[k*5 +: 5]};
        wdata_d[slot*64 +: 64]     = {32'd0, in_wdata[k*32 +: 32]};
        slot                       = slot + 1;
      end
    end
    base_d = base_q + 8'(slot);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q  <= '0;
      valid_q <= '0;
      index_q <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      wen_q   <= '0;
      wdest_q <= '0;
      wdata_q <= '0;
    end else begin
      base_q  <= base_d;
      valid_q <= valid_d;
      index_q <= index_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wen_q   <= wen_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_wen   = wen_q;
  assign out_wdest = wdest_q;
  assign out_wdata = wdata_q;

  // ---------------- store event FIFO ----------------
  logic [7:0]  kind_mem  [STQ_DEPTH];
  logic [31:0] paddr_mem [STQ_DEPTH];
  logic [31:0] vaddr_mem [STQ_DEPTH];
  logic [31:0] data_mem  [STQ_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] free_cnt;
  logic [CntW-1:0] push_cnt;
  logic            stq_pop;
  logic            drop;
  logic [COMMIT_W-1:0] push_en;
  logic [PtrW-1:0]     push_addr [COMMIT_W];

  // Free space ignores this cycle's pop, so a same-cycle pop never makes room.
  assign free_cnt     = CntW'(STQ_DEPTH) - count_q;
  assign commit_ready = (free_cnt >= CntW'(COMMIT_W));
  assign stq_pop      = (count_q != '0);

  always_comb begin
    int n;
    n       = 0;
    drop    = 1'b0;
    push_en = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      push_addr[k] = '0;
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (in_valid[k] && in_st[k]) begin
        if (CntW'(n) < free_cnt) begin
          push_en[k]   = 1'b1;
          push_addr[k] = wr_ptr_q + PtrW'(n);
          n            = n + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    push_cnt = CntW'(n);
    count_d  = count_q + push_cnt - CntW'(stq_pop);
  end

  // Storage needs no reset: pointers and count gate what is ever read.
  always_ff @(posedge clock) begin
    for (int k = 0; k < COMMIT_W; k++) begin
      if (push_en[k]) begin
        kind_mem[push_addr[k]]  <= in_st_kind[k*8 +: 8];
        paddr_mem[push_addr[k]] <= in_st_paddr[k*32 +: 32];
        vaddr_mem[push_addr[k]] <= in_st_vaddr[k*32 +: 32];
        data_mem[push_addr[k]]  <= in_st_data[k*32 +: 32];
      end
    end
  end

  // ---------------- store event output ----------------
  logic [7:0]  st_valid_q;
  logic [7:0]  st_index_q;
  logic [31:0] st_paddr_q, st_vaddr_q, st_data_q;
  logic        st_overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      st_valid_q    <= '0;
      st_index_q    <= '0;
      st_paddr_q    <= '0;
      st_vaddr_q    <= '0;
      st_data_q     <= '0;
      st_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(push_cnt);
      count_q  <= count_d;
      if (drop) begin
        st_overflow_q <= 1'b1;
      end
      if (stq_pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        st_valid_q <= kind_mem[rd_ptr_q];
        st_index_q <= st_index_q + 8'd1;
        st_paddr_q <= paddr_mem[rd_ptr_q];
        st_vaddr_q <= vaddr_mem[rd_ptr_q];
        st_data_q  <= data_mem[rd_ptr_q];
      end else begin
        st_valid_q <= 8'd0;
      end
    end
  end

  assign st_valid    = st_valid_q;
  assign st_index    = st_index_q;
  assign st_paddr    = {32'd0, st_paddr_q};
  assign st_vaddr    = {32'd0, st_vaddr_q};
  assign st_data     = {32'd0, st_data_q};
  assign st_overflow = st_overflow_q;

endmodule

// File: tb/tb_diff_commit_packer.sv
// Directed bench for diff_commit_packer: compaction, index wrap, store streaming,
// backpressure, overflow and mid-stream reset.
module tb_diff_commit_packer;

  logic         clock;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_pc;
  logic [127:0] in_instr;
  logic [3:0]   in_wen;
  logic [19:0]  in_wdest;
  logic [127:0] in_wdata;
  logic [3:0]   in_st;
  logic [127:0] in_st_paddr;
  logic [127:0] in_st_vaddr;
  logic [127:0] in_st_data;
  logic [31:0]  in_st_kind;
  logic         commit_ready;
  logic [3:0]   out_valid;
  logic [31:0]  out_index;
  logic [255:0] out_pc;
  logic [127:0] out_instr;
  logic [3:0]   out_wen;
  logic [31:0]  out_wdest;
  logic [255:0] out_wdata;
  logic [7:0]   st_valid;
  logic [7:0]   st_index;
  logic [63:0]  st_paddr;
  logic [63:0]  st_vaddr;
  logic [63:0]  st_data;
  logic         st_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  diff_commit_packer #(
    .COMMIT_W  (4),
    .STQ_DEPTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_wen       (in_wen),
    .in_wdest     (in_wdest),
    .in_wdata     (in_wdata),
    .in_st        (in_st),
    .in_st_paddr  (in_st_paddr),
    .in_st_vaddr  (in_st_vaddr),
    .in_st_data   (in_st_data),
    .in_st_kind   (in_st_kind),
    .commit_ready (commit_ready),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_wen      (out_wen),
    .out_wdest    (out_wdest),
    .out_wdata    (out_wdata),
    .st_valid     (st_valid),
    .st_index     (st_index),
    .st_paddr     (st_paddr),
    .st_vaddr     (st_vaddr),
    .st_data      (st_data),
    .st_overflow  (st_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    in_valid    = '0;
    in_pc       = '0;
    in_instr    = '0;
    in_wen      = '0;
    in_wdest    = '0;
    in_wdata    = '0;
    in_st       = '0;
    in_st_paddr = '0;
    in_st_vaddr = '0;
    in_st_data  = '0;
    in_st_kind  = '0;
  endtask

  // Store on port k; vaddr and data are derived from paddr so one value pins the entry.
  task automatic put_store(input int k, input logic [31:0] pa, input logic [7:0] kind);
    in_valid[k]             = 1'b1;
    in_st[k]                = 1'b1;
    in_st_paddr[k*32 +: 32] = pa;
    in_st_vaddr[k*32 +: 32] = pa | 32'h8000_0000;
    in_st_data[k*32 +: 32]  = ~pa;
    in_st_kind[k*8 +: 8]    = kind;
  endtask

  initial begin
    logic [7:0]  burst_kind [4];
    logic [31:0] drain_pa   [7];
    burst_kind = '{8'h01, 8'h03, 8'h0f, 8'hff};
    drain_pa   = '{32'h214, 32'h218, 32'h300, 32'h304, 32'h308, 32'h400, 32'h404};

    // ---- reset ----
    reset = 1'b1;
    clr();
    tick();
    tick();
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_st_valid", st_valid, 8'h00);
    check("rst_out_pc", out_pc, 256'd0);
    check("rst_st_overflow", st_overflow, 1'b0);
    check("rst_commit_ready", commit_ready, 1'b1);
    reset = 1'b0;

    // ---- compaction 1010 ----
    in_valid             = 4'b1010;
    in_pc[31:0]          = 32'hdead_beef;
    in_wen[0]            = 1'b1;
    in_pc[63:32]         = 32'h1c00_0004;
    in_instr[63:32]      = 32'h0010_0093;
    in_wen[1]            = 1'b1;
    in_wdest[9:5]        = 5'd1;
    in_wdata[63:32]      = 32'h5;
    in_pc[127:96]        = 32'h1c00_000c;
    in_instr[127:96]     = 32'h0000_8067;
    in_wen[3]            = 1'b0;
    in_wdest[19:15]      = 5'd3;
    in_wdata[127:96]     = 32'h77;
    tick();
    check("cmp_out_valid", out_valid, 4'b0011);
    check("cmp_out_pc", out_pc, {128'd0, 64'h1c00_000c, 64'h1c00_0004});
    check("cmp_out_index", out_index, 32'h0000_0201);
    check("cmp_out_instr", out_instr, {64'd0, 32'h0000_8067, 32'h0010_0093});
    check("cmp_out_wen", out_wen, 4'b0001);
    check("cmp_out_wdest", out_wdest, 32'h0000_0301);
    check("cmp_out_wdata", out_wdata, {128'd0, 64'h77, 64'h5});

    // ---- index wrap: base 2 -> 253 via single retires on port 2 ----
    clr();
    in_valid        = 4'b0100;
    in_pc[95:64]    = 32'h1c00_1000;
    repeat (251) tick();
    check("wrap_last_single_index", out_index, 32'd253);
    check("wrap_last_single_valid", out_valid, 4'b0001);
    check("wrap_last_single_pc", out_pc, {192'd0, 64'h1c00_1000});
    in_valid = 4'b1111;
    tick();
    check("wrap_quad_index", out_index, 32'h0100_fffe);
    check("wrap_quad_valid", out_valid, 4'b1111);
    in_valid = 4'b0001;
    tick();
    check("wrap_after_index", out_index, 32'h0000_0002);
    clr();
    tick();
    check("idle_out_valid", out_valid, 4'b0000);
    check("idle_out_index", out_index, 32'd0);

    // ---- store burst: 4 stores in one cycle ----
    check("burst_ready_before", commit_ready, 1'b1);
    for (int k = 0; k < 4; k++) put_store(k, 32'h100 + 32'(4 * k), burst_kind[k]);
    tick();
    clr();
    check("burst_no_pop_yet", st_valid, 8'h00);
    check("burst_ready_cnt4", commit_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst_st_valid", st_valid, burst_kind[i]);
      check("burst_st_paddr", st_paddr, 64'h100 + 64'(4 * i));
      check("burst_st_index", st_index, 8'(i + 1));
      if (i == 0) begin
        check("burst_st_vaddr", st_vaddr, 64'h8000_0100);
        check("burst_st_data", st_data, 64'h0000_0000_ffff_feff);
      end
    end
    tick();
    check("burst_idle_valid", st_valid, 8'h00);
    check("burst_idle_hold_paddr", st_paddr, 64'h10c);
    check("burst_idle_hold_index", st_index, 8'd4);

    // ---- backpressure ----
    for (int k = 0; k < 4; k++) put_store(k, 32'h200 + 32'(4 * k), 8'h0f);
    tick();
    clr();
    check("bp_ready_cnt4", commit_ready, 1'b1);
    for (int k = 0; k < 3; k++) put_store(k, 32'h210 + 32'(4 * k), 8'h0f);
    tick();
    clr();
    check("bp_ready_cnt6", commit_ready, 1'b0);
    check("bp_pop1_paddr", st_paddr, 64'h200);
    check("bp_pop1_index", st_index, 8'd5);
    tick();
    check("bp_ready_cnt5", commit_ready, 1'b0);
    tick();
    check("bp_ready_cnt4_again", commit_ready, 1'b1);
    check("bp_pop3_paddr", st_paddr, 64'h208);
    check("bp_no_overflow", st_overflow, 1'b0);

    // ---- overflow: refill to 6, then force 4 stores ----
    for (int k = 0; k < 3; k++) put_store(k, 32'h300 + 32'(4 * k), 8'h0f);
    tick();
    clr();
    check("ovf_ready_cnt6", commit_ready, 1'b0);
    check("ovf_pre_paddr", st_paddr, 64'h20c);
    check("ovf_pre_flag", st_overflow, 1'b0);
    for (int k = 0; k < 4; k++) put_store(k, 32'h400 + 32'(4 * k), 8'h0f);
    tick();
    clr();
    check("ovf_flag_set", st_overflow, 1'b1);
    check("ovf_pop_paddr", st_paddr, 64'h210);
    check("ovf_pop_index", st_index, 8'd9);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("ovf_drain_valid", st_valid, 8'h0f);
      check("ovf_drain_paddr", st_paddr, {32'd0, drain_pa[i]});
      check("ovf_drain_index", st_index, 8'(10 + i));
    end
    tick();
    check("ovf_drained_valid", st_valid, 8'h00);
    check("ovf_drained_index", st_index, 8'd16);
    check("ovf_sticky", st_overflow, 1'b1);
    check("ovf_ready_empty", commit_ready, 1'b1);

    // ---- reset mid-stream with 5 stores queued ----
    for (int k = 0; k < 4; k++) put_store(k, 32'h500 + 32'(4 * k), 8'h03);
    tick();
    clr();
    for (int k = 0; k < 2; k++) put_store(k, 32'h510 + 32'(4 * k), 8'h03);
    tick();
    clr();
    check("mrst_ready_cnt5", commit_ready, 1'b0);
    check("mrst_pre_paddr", st_paddr, 64'h500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_out_valid", out_valid, 4'b0000);
    check("mrst_st_valid", st_valid, 8'h00);
    check("mrst_ready", commit_ready, 1'b1);
    check("mrst_overflow_clr", st_overflow, 1'b0);
    check("mrst_st_paddr", st_paddr, 64'd0);
    check("mrst_st_index", st_index, 8'd0);
    tick();
    check("mrst_discarded", st_valid, 8'h00);
    in_valid = 4'b0001;
    tick();
    clr();
    check("mrst_first_index", out_index, 32'h0000_0001);
    check("mrst_first_valid", out_valid, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_commit_packer.md
Name: diff_commit_packer

Overview:
- Producer side of the difftest commit interface: sits between the core's commit stage (ROB retire ports) and the difftest bridge.
- Each cycle it takes up to 4 retiring instructions and compacts the valid ones, in order, into commit slots 0..3.
- It assigns a running 8-bit commit index and registers every slot one cycle before presenting it.
- Retired stores go into a FIFO and are emitted as store events, one per cycle. Backpressure is returned to commit so no store event is ever lost.

Parameters:
- COMMIT_W, 4, commit ports in and slots out; fixed at 4 to match the bridge.
- STQ_DEPTH, 8, store-event FIFO depth; power of 2, must be ≥ COMMIT_W.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  4  per-port retire valid; any pattern allowed, e.g. 4'b1010
- in_pc  in  128  4x32 retire PC; port k at [32k+31:32k]
- in_instr  in  128  4x32 instruction word
- in_wen  in  4  GPR write enable
- in_wdest  in  20  4x5 destination register
- in_wdata  in  128  4x32 write data
- in_st  in  4  port retires a store
- in_st_paddr  in  128  4x32 store physical address
- in_st_vaddr  in  128  4x32 store virtual address
- in_st_data  in  128  4x32 store data, already lane-aligned
- in_st_kind  in  32  4x8 store valid encoding; bridge storeValid format
- commit_ready  out  1  high when FIFO free entries ≥ 4; commit must not retire while low
- out_valid  out  4  slot valid, packed from slot 0 upward
- out_index  out  32  4x8 slot commit index
- out_pc  out  256  4x64, zero-extended
- out_instr  out  128  4x32
- out_wen  out  4  slot GPR write enable
- out_wdest  out  32  4x8, zero-extended
- out_wdata  out  256  4x64, zero-extended
- st_valid  out  8  store kind of head entry; 0 when idle
- st_index  out  8  store event index
- st_paddr  out  64  zero-extended
- st_vaddr  out  64  zero-extended
- st_data  out  64  zero-extended
- st_overflow  out  1  sticky error flag

Behaviour:
- Compaction: out slot j holds the j-th set bit of in_valid, counted from port 0 upward.
  - Example: in_valid=1010 → slot0=port1, slot1=port3, out_valid=0011.
  - Slot fields are gated by valid: an invalid slot drives all fields 0, including wen.
- Latency: every out_* is registered; inputs at cycle t appear at t+1.
- Commit index:
  - 8-bit base counter, reset 0.
  - out_index of slot j = base + j + 1 (mod 256).
  - base += popcount(in_valid), wrapping at 256 (e.g. base=254 with 4 valid → indices 255,0,1,2; new base 2).
  - Invalid slots output index 0.
- Store FIFO:
  - Depth STQ_DEPTH, holding {kind, paddr, vaddr, data}.
  - Entries are pushed for ports with in_valid&in_st, in port order; up to 4 per cycle.
  - A port with in_st=1 and in_valid=0 is ignored.
  - One entry pops per cycle when non-empty; push and pop in the same cycle are both allowed.
  - Count update: count' = count + pushes − pop.
  - Pointers wrap modulo STQ_DEPTH.
- Store output:
  - Registered from the FIFO head; the popped entry appears on st_* the following cycle.
  - st_index is an 8-bit counter, reset 0. It increments on each pop; the emitted index is the pre-increment value plus 1.
  - With no pop, st_valid=0 and the data fields hold their previous values.
- commit_ready is combinational: (STQ_DEPTH − count) ≥ 4, evaluated on current count before this cycle's pop.
- Overflow: if pushes exceed free space, the excess entries are dropped, st_overflow is set, and it stays set until reset. Retirements while commit_ready=0 are a protocol error; this flag exposes them.
- Reset:
  - All out_valid=0 and st_valid=0; all data outputs 0.
  - FIFO emptied; both counters 0; st_overflow 0.
  - commit_ready=1 in the cycle after reset is released.
  - Reset mid-operation discards buffered stores without emitting them.

Test Plan:
- Compaction: in_valid=1010, pc1=0x1c000004, pc3=0x1c00000c, base=0 → next cycle out_valid=0011, out_pc slot0=0x1c000004, slot1=0x1c00000c, indices 1,2.
- Index wrap: drive 253 single retires, then in_valid=1111 → indices 254,255,0,1; following single retire → index 2.
- Store burst: 4 stores in one cycle with paddr 0x100,0x104,0x108,0x10c, then idle → st_valid non-zero on 4 consecutive cycles in port order, st_index 1..4.
- Backpressure: 6 stores queued (STQ_DEPTH=8) → commit_ready=0. After 3 pops (count ≤ 4), commit_ready=1. st_overflow stays 0.
- Overflow: force 4 stores while count=6 → 2 entries accepted, st_overflow=1, later output shows only the first 2.
- Reset mid-stream: assert reset with 5 stores queued → next cycle all valids 0, commit_ready=1. First post-reset commit has index 1.
